// File: rtl/ofm_reader.sv
// ofm_reader: drains one frame of OFM words from the OFM buffer into a valid/ready stream.
// Optional build macro OFM_RELU_EN clamps negative words to zero before they are queued.
module ofm_reader #(
    parameter int          N     = 16,
    parameter int unsigned WORDS = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ofm_rd,
    output logic [31:0]  ofm_adr,
    input  logic [N-1:0] ofm_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [31:0] LAST = 32'(WORDS - 1);

    state_t       state;
    logic [31:0]  adr;
    logic [31:0]  wcnt;
    logic         inflight;
    logic [N-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;
    logic         rd;
    logic         rd_last;
    logic [2:0]   lvl;
    logic [N-1:0] wdata;

    assign push      = inflight;
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rptr];
    assign out_last  = out_valid & (wcnt == LAST);

    // Level the FIFO will reach once the in-flight read lands and this cycle's pop leaves.
    assign lvl     = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd      = (state == READ) & (lvl < 3'd2);
    assign rd_last = rd & (adr == LAST);
    assign ofm_rd  = rd;
    assign ofm_adr = adr;

`ifdef OFM_RELU_EN
    assign wdata = ofm_data[N-1] ? '0 : ofm_data;
`else
    assign wdata = ofm_data;
`endif

    // Frame sequencing with registered busy/done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop & out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Read address walks 0..WORDS-1 and parks at 0 outside a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr <= '0;
        end else if (rd_last) begin
            adr <= '0;
        end else if (rd) begin
            adr <= adr + 32'd1;
        end else if (state == IDLE) begin
            adr <= '0;
        end
    end

    // Marks a read whose data arrives next cycle; cleared by reset so stale data is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight <= 1'b0;
        else      inflight <= rd;
    end

    // Two-entry FIFO covering the one-cycle buffer latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Index of the word at the FIFO head, used to flag the final word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
        end else if (pop) begin
            wcnt <= out_last ? 32'd0 : wcnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ofm_reader.sv
// tb_ofm_reader: scoreboard bench for ofm_reader (WORDS=25 and WORDS=1 instances).
// Covers full-rate, stalled, backpressured, reset-abort and single-word frames.
module tb_ofm_reader;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         ofm_rd, out_valid, out_last, busy, done;
    logic         out_ready = 1'b1;
    logic [31:0]  ofm_adr;
    logic [N-1:0] ofm_data = '0;
    logic [N-1:0] out_data;
    logic [N-1:0] mem [25];

    logic         start1 = 1'b0;
    logic         r1 = 1'b1;
    logic         rd1, v1, l1, b1, dn1;
    logic [31:0]  adr1;
    logic [N-1:0] data1 = '0;
    logic [N-1:0] d1;

    typedef struct {
        logic [N-1:0] d;
        logic         l;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rmode = 0;
    int   nrd = 0;
    int   npop = 0;
    int   occ = 0;
    logic rdq = 1'b0;
    int   last_hs = -100;
    logic hold = 1'b0;
    logic [N-1:0] hd;
    logic hl;

    ofm_reader #(.N(N), .WORDS(25)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ofm_rd(ofm_rd), .ofm_adr(ofm_adr), .ofm_data(ofm_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    ofm_reader #(.N(N), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .ofm_rd(rd1), .ofm_adr(adr1), .ofm_data(data1),
        .out_valid(v1), .out_ready(r1),
        .out_data(d1), .out_last(l1),
        .busy(b1), .done(dn1)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    function automatic logic [N-1:0] relu(input logic [N-1:0] v);
`ifdef OFM_RELU_EN
        return v[N-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Buffer models: registered read, one cycle latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ofm_rd) ofm_data <= mem[ofm_adr[4:0]];
        if (rd1) data1 <= 16'd7;
        if (ofm_rd) nrd <= nrd + 1;
        if (out_valid && out_ready) npop <= npop + 1;
    end

    // Independent occupancy model: reads land one cycle later, pops leave.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= 0;
            rdq <= 1'b0;
        end else begin
            rdq <= ofm_rd;
            occ <= occ + int'(rdq) - int'(out_valid && out_ready);
        end
    end

    // Ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) out_ready = 1'b1;
            else if (rmode == 1) out_ready = ~out_ready;
            else out_ready = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious word: got %0h want none", out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word data", 64'(out_data), 64'(e.d));
                    chk("word last", 64'(out_last), 64'(e.l));
                    if (out_last) last_hs = cyc;
                end
            end
            if (ofm_rd) begin
                chk("rd room", 64'((occ + int'(rdq)
                    - int'(out_valid && out_ready)) < 2), 64'(1));
                chk("rd adr range", 64'(ofm_adr < 32'd25), 64'(1));
            end
            if (hold) begin
                chk("stall data", 64'(out_data), 64'(hd));
                chk("stall last", 64'(out_last), 64'(hl));
            end
            hold = out_valid && !out_ready;
            hd   = out_data;
            hl   = out_last;
            if (done) begin
                chk("done timing", 64'(cyc), 64'(last_hs + 1));
                chk("busy in done", 64'(busy), 64'(1));
            end
        end
    end

    task automatic frame(input string nm, input int mode, input int abort_at);
        int n;
        int r0;
        int p0;
        for (int i = 0; i < 25; i++) begin
            exp_t e;
            e.d = relu(mem[i]);
            e.l = (i == 24);
            q.push_back(e);
        end
        rmode = mode;
        r0 = nrd;
        p0 = npop;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({nm, " first rd"}, 64'({ofm_rd, ofm_adr}), 64'({1'b1, 32'd0}));
        chk({nm, " busy"}, 64'(busy), 64'(1));
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(2));
        if (mode == 2) begin
            repeat (8) @(posedge clk);
            #1;
            chk({nm, " stalled reads"}, 64'(nrd - r0), 64'(2));
            chk({nm, " stalled rd low"}, 64'(ofm_rd), 64'(0));
            rmode = 0;
        end
        if (abort_at > 0) begin
            n = 0;
            while (npop - p0 < abort_at && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk({nm, " reached abort"}, 64'(npop - p0), 64'(abort_at));
            rst = 1'b0;
            q.delete();
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            chk({nm, " abort busy"}, 64'(busy), 64'(0));
            chk({nm, " abort valid"}, 64'(out_valid), 64'(0));
            chk({nm, " abort adr"}, 64'(ofm_adr), 64'(0));
            return;
        end
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " done seen"}, 64'(done), 64'(1));
        @(posedge clk); #1;
        chk({nm, " idle busy"}, 64'(busy), 64'(0));
        chk({nm, " idle done"}, 64'(done), 64'(0));
        chk({nm, " queue empty"}, 64'(q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 25; i++) mem[i] = 16'(i);
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", 64'(out_valid), 64'(0));
        chk("rst data", 64'(out_data), 64'(0));
        chk("rst last", 64'(out_last), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst rd", 64'(ofm_rd), 64'(0));
        chk("rst adr", 64'(ofm_adr), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        frame("full", 0, 0);
        frame("toggle", 1, 0);
        frame("stall", 2, 0);
        frame("abort", 0, 12);
        frame("restart", 0, 0);

        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        chk("w1 first rd", 64'({rd1, adr1}), 64'({1'b1, 32'd0}));
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        chk("w1 valid", 64'(v1), 64'(1));
        chk("w1 data", 64'(d1), 64'(7));
        chk("w1 last", 64'(l1), 64'(1));
        @(posedge clk); #1;
        chk("w1 done", 64'(dn1), 64'(1));
        chk("w1 busy in done", 64'(b1), 64'(1));
        chk("w1 empty", 64'(v1), 64'(0));
        @(posedge clk); #1;
        chk("w1 idle busy", 64'(b1), 64'(0));
        chk("w1 idle done", 64'(dn1), 64'(0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("w1 no redrain", 64'({b1, rd1}), 64'(0));
        end

        mem[0] = 16'hFFFF;
        mem[1] = 16'h0005;
        frame("relu", 0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
